// File: rtl/axi4_id_tracker_if.sv
// Handshake bundle for the AXI4 ID tracker: read/write request ports,
// the shared downstream issue port and the response retire strobe.
interface axi4_id_tracker_if;
  logic       rd_req_valid;
  logic       rd_req_ready;
  logic [3:0] rd_req_id;
  logic       wr_req_valid;
  logic       wr_req_ready;
  logic [3:0] wr_req_id;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_id;
  logic       out_is_write;
  logic       rsp_valid;
  logic       rsp_last;
  logic       rsp_is_write;
  logic [3:0] rsp_id;

  // Tracker side.
  modport slave (
    input  rd_req_valid, rd_req_id, wr_req_valid, wr_req_id, out_ready,
           rsp_valid, rsp_last, rsp_is_write, rsp_id,
    output rd_req_ready, wr_req_ready, out_valid, out_id, out_is_write
  );

  // Requester / downstream / responder side.
  modport master (
    output rd_req_valid, rd_req_id, wr_req_valid, wr_req_id, out_ready,
           rsp_valid, rsp_last, rsp_is_write, rsp_id,
    input  rd_req_ready, wr_req_ready, out_valid, out_id, out_is_write
  );
endinterface

// File: rtl/axi4_id_tracker.sv
// AXI4 outstanding-transaction tracker. Counts in-flight transactions per
// (direction, ID) and in total, admits new requests through a round-robin
// read/write arbiter into a one-entry issue register, retires on the last
// response beat, and flags illegal IDs and orphan responses.
module axi4_id_tracker #(
  parameter int NUM_IDS    = 8,
  parameter int MAX_PER_ID = 4,
  parameter int MAX_TOTAL  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  axi4_id_tracker_if.slave   bus,
  input  logic               err_clear,
  output logic               err_illegal_id,
  output logic               err_orphan_rsp,
  output logic [4:0]         outstanding_total,
  output logic               busy
);

  localparam int              CW        = $clog2(MAX_PER_ID + 1);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(MAX_PER_ID);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [4:0]      TOTAL_MAX = 5'(MAX_TOTAL);
  localparam logic [4:0]      ID_LIMIT  = 5'(NUM_IDS);

  logic [CW-1:0] rd_cnt [NUM_IDS];
  logic [CW-1:0] wr_cnt [NUM_IDS];
  logic [4:0]    total_q;
  logic          prio_wr_q;
  logic          out_valid_q;
  logic [3:0]    out_id_q;
  logic          out_is_write_q;
  logic          err_illegal_q;
  logic          err_orphan_q;

  logic [CW-1:0]      rd_cnt_sel, wr_cnt_sel, rsp_cnt_sel;
  logic [NUM_IDS-1:0] rd_inc, rd_dec, wr_inc, wr_dec;

  logic rd_legal, wr_legal, rsp_legal;
  logic slot_free, room;
  logic rd_open, wr_open, rd_elig, wr_elig;
  logic rd_grant, wr_grant, rd_take, wr_take;
  logic rsp_fire, retire, orphan, illegal_drop;

  // Legality and admission room come from registered state only, so a
  // same-cycle retire never unblocks a same-cycle request.
  assign rd_legal  = {1'b0, bus.rd_req_id} < ID_LIMIT;
  assign wr_legal  = {1'b0, bus.wr_req_id} < ID_LIMIT;
  assign rsp_legal = {1'b0, bus.rsp_id}    < ID_LIMIT;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign room      = (total_q < TOTAL_MAX) && slot_free;

  // Illegal IDs are dropped without touching the slot or counters, so they
  // are always admissible.
  assign rd_open  = !rd_legal || ((rd_cnt_sel < CNT_MAX) && room);
  assign wr_open  = !wr_legal || ((wr_cnt_sel < CNT_MAX) && room);
  assign rd_elig  = bus.rd_req_valid && rd_open;
  assign wr_elig  = bus.wr_req_valid && wr_open;
  assign rd_grant = rd_elig && (!prio_wr_q || !wr_elig);
  assign wr_grant = wr_elig && ( prio_wr_q || !rd_elig);
  assign rd_take  = rd_grant && rd_legal;
  assign wr_take  = wr_grant && wr_legal;

  // Each ready looks at its own ID and the other side's valid, never at its own valid.
  assign bus.rd_req_ready = reset_n && rd_open && (!prio_wr_q || !wr_elig);
  assign bus.wr_req_ready = reset_n && wr_open && ( prio_wr_q || !rd_elig);

  assign rsp_fire     = bus.rsp_valid && bus.rsp_last;
  assign retire       = rsp_fire && rsp_legal && (rsp_cnt_sel != '0);
  assign orphan       = rsp_fire && !retire;
  assign illegal_drop = (rd_grant && !rd_legal) || (wr_grant && !wr_legal);

  // Select the counters addressed by this cycle's IDs and form per-ID up/down strobes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    rd_cnt_sel  = '0;
    wr_cnt_sel  = '0;
    rsp_cnt_sel = '0;
    rd_inc      = '0;
    rd_dec      = '0;
    wr_inc      = '0;
    wr_dec      = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      if (bus.rd_req_id == 4'(i)) rd_cnt_sel = rd_cnt[i];
      if (bus.wr_req_id == 4'(i)) wr_cnt_sel = wr_cnt[i];
      if (bus.rsp_id == 4'(i))    rsp_cnt_sel = bus.rsp_is_write ? wr_cnt[i] : rd_cnt[i];
      rd_inc[i] = rd_take && (bus.rd_req_id == 4'(i));
      wr_inc[i] = wr_take && (bus.wr_req_id == 4'(i));
      rd_dec[i] = retire && !bus.rsp_is_write && (bus.rsp_id == 4'(i));
      wr_dec[i] = retire &&  bus.rsp_is_write && (bus.rsp_id == 4'(i));
    end
  end

  // Per-(direction, ID) counters; a grant and a retire on the same counter cancel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these counters are plain flops rather than a RAM, so they must clear on reset like any other state.
      for (int i = 0; i < NUM_IDS; i++) begin
        rd_cnt[i] <= '0;
        wr_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rd_inc[i] && !rd_dec[i])      rd_cnt[i] <= rd_cnt[i] + CNT_ONE;
        else if (rd_dec[i] && !rd_inc[i]) rd_cnt[i] <= rd_cnt[i] - CNT_ONE;
        if (wr_inc[i] && !wr_dec[i])      wr_cnt[i] <= wr_cnt[i] + CNT_ONE;
        else if (wr_dec[i] && !wr_inc[i]) wr_cnt[i] <= wr_cnt[i] - CNT_ONE;
      end
    end
  end

  // Total outstanding count, netting a same-cycle admit and retire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      total_q <= '0;
    end else begin
      case ({rd_take || wr_take, retire})
        2'b10:   total_q <= total_q + 5'd1;
        2'b01:   total_q <= total_q - 5'd1;
        default: total_q <= total_q;
      endcase
    end
  end

  // One-entry issue register plus the round-robin pointer (flips after any grant, dropped ones included).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      out_id_q       <= '0;
      out_is_write_q <= 1'b0;
      prio_wr_q      <= 1'b0;
    end else begin
      if (rd_take) begin
        out_valid_q    <= 1'b1;
        out_id_q       <= bus.rd_req_id;
        out_is_write_q <= 1'b0;
      end else if (wr_take) begin
        out_valid_q    <= 1'b1;
        out_id_q       <= bus.wr_req_id;
        out_is_write_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q    <= 1'b0;
      end
      if (rd_grant)      prio_wr_q <= 1'b1;
      else if (wr_grant) prio_wr_q <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_illegal_q <= 1'b0;
      err_orphan_q  <= 1'b0;
    end else begin
      if (illegal_drop)   err_illegal_q <= 1'b1;
      else if (err_clear) err_illegal_q <= 1'b0;
      if (orphan)         err_orphan_q  <= 1'b1;
      else if (err_clear) err_orphan_q  <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_id        = out_id_q;
  assign bus.out_is_write  = out_is_write_q;
  assign err_illegal_id    = err_illegal_q;
  assign err_orphan_rsp    = err_orphan_q;
  assign outstanding_total = total_q;
  assign busy              = (total_q != '0) || out_valid_q;

endmodule

// File: tb/tb_axi4_id_tracker.sv
// Self-checking bench for axi4_id_tracker: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of counts, arbitration and the issue slot.
module tb_axi4_id_tracker;
  localparam int NUM_IDS    = 8;
  localparam int MAX_PER_ID = 4;
  localparam int MAX_TOTAL  = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       err_clear = 1'b0;
  logic       err_illegal_id, err_orphan_rsp, busy;
  logic [4:0] outstanding_total;

  axi4_id_tracker_if bus();

  axi4_id_tracker #(.NUM_IDS(NUM_IDS), .MAX_PER_ID(MAX_PER_ID), .MAX_TOTAL(MAX_TOTAL)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .bus               (bus),
    .err_clear         (err_clear),
    .err_illegal_id    (err_illegal_id),
    .err_orphan_rsp    (err_orphan_rsp),
    .outstanding_total (outstanding_total),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: outstanding counts, issue slot, turn, sticky errors.
  int m_cnt [2][16];
  int m_total;
  bit m_prio_wr;
  bit m_ov;
  int m_oid;
  bit m_owr;
  bit m_eill, m_eorph;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) m_cnt[d][i] = 0;
    m_total = 0; m_prio_wr = 0; m_ov = 0; m_oid = 0; m_owr = 0;
    m_eill = 0; m_eorph = 0;
  endtask

  task automatic idle();
    bus.rd_req_valid = 0; bus.rd_req_id = 0;
    bus.wr_req_valid = 0; bus.wr_req_id = 0;
    bus.out_ready = 1;
    bus.rsp_valid = 0; bus.rsp_last = 0; bus.rsp_is_write = 0; bus.rsp_id = 0;
    err_clear = 0;
  endtask

  // Called at a falling edge with inputs applied: compare outputs against the
  // model, advance the model across the rising edge, return at the next falling edge.
  task automatic step();
    bit rd_leg, wr_leg, slot_free, rd_ok, wr_ok, rd_el, wr_el, rd_win, wr_win;
    bit rsp_fire, rsp_ok, new_ill;
    int rid, wid, sid, sdir;
    #1;
    if (!reset_n) begin
      check("rst_rd_ready", bus.rd_req_ready, 0);
      check("rst_wr_ready", bus.wr_req_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_id", bus.out_id, 0);
      check("rst_out_is_write", bus.out_is_write, 0);
      check("rst_total", outstanding_total, 0);
      check("rst_busy", busy, 0);
      check("rst_err_illegal", err_illegal_id, 0);
      check("rst_err_orphan", err_orphan_rsp, 0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      return;
    end
    rid = int'(bus.rd_req_id);
    wid = int'(bus.wr_req_id);
    sid = int'(bus.rsp_id);
    sdir = bus.rsp_is_write ? 1 : 0;
    rd_leg = rid < NUM_IDS;
    wr_leg = wid < NUM_IDS;
    slot_free = !m_ov || bus.out_ready;
    rd_ok = !rd_leg || (m_cnt[0][rid] < MAX_PER_ID && m_total < MAX_TOTAL && slot_free);
    wr_ok = !wr_leg || (m_cnt[1][wid] < MAX_PER_ID && m_total < MAX_TOTAL && slot_free);
    rd_el = bus.rd_req_valid && rd_ok;
    wr_el = bus.wr_req_valid && wr_ok;
    rd_win = rd_el && (!m_prio_wr || !wr_el);
    wr_win = wr_el && !rd_win;

    check("rd_req_ready", bus.rd_req_ready, rd_ok && (!m_prio_wr || !wr_el));
    check("wr_req_ready", bus.wr_req_ready, wr_ok && (m_prio_wr || !rd_el));
    check("out_valid", bus.out_valid, m_ov);
    check("out_id", bus.out_id, m_oid);
    check("out_is_write", bus.out_is_write, m_owr);
    check("outstanding_total", outstanding_total, m_total);
    check("busy", busy, (m_total != 0) || m_ov);
    check("err_illegal_id", err_illegal_id, m_eill);
    check("err_orphan_rsp", err_orphan_rsp, m_eorph);

    rsp_fire = bus.rsp_valid && bus.rsp_last;
    rsp_ok = rsp_fire && (sid < NUM_IDS) && (m_cnt[sdir][sid] > 0);
    new_ill = (rd_win && !rd_leg) || (wr_win && !wr_leg);

    if (rd_win && rd_leg) begin
      m_ov = 1; m_oid = rid; m_owr = 0;
      m_cnt[0][rid]++; m_total++;
    end else if (wr_win && wr_leg) begin
      m_ov = 1; m_oid = wid; m_owr = 1;
      m_cnt[1][wid]++; m_total++;
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    if (rsp_ok) begin
      m_cnt[sdir][sid]--; m_total--;
    end
    if (rd_win) m_prio_wr = 1;
    else if (wr_win) m_prio_wr = 0;
    if (new_ill) m_eill = 1;
    else if (err_clear) m_eill = 0;
    if (rsp_fire && !rsp_ok) m_eorph = 1;
    else if (err_clear) m_eorph = 0;

    @(posedge clock);
    @(negedge clock);
  endtask

  // Retire everything the model holds outstanding, one response per cycle.
  task automatic drain();
    idle();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NUM_IDS; i++)
        while (m_cnt[d][i] > 0) begin
          bus.rsp_valid = 1; bus.rsp_last = 1;
          bus.rsp_is_write = (d == 1); bus.rsp_id = 4'(i);
          step();
        end
    idle();
    step();
    check("drain_total", outstanding_total, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle();
    // Reset state, with an illegal-ID request present that must not be readied.
    bus.rd_req_valid = 1; bus.rd_req_id = 4'd9;
    repeat (2) @(negedge clock);
    step();
    reset_n = 1;
    idle();

    // Both sides valid every cycle: grants alternate starting with read.
    bus.rd_req_valid = 1; bus.rd_req_id = 4'd2;
    bus.wr_req_valid = 1; bus.wr_req_id = 4'd5;
    #1 check("first_rd_ready", bus.rd_req_ready, 1);
    check("first_wr_ready", bus.wr_req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("alt_out_valid", bus.out_valid, 1);
      check("alt_direction", bus.out_is_write, k % 2);
      check("alt_id", bus.out_id, (k % 2 == 0) ? 2 : 5);
    end
    check("alt_total", outstanding_total, 4);
    drain();

    // Per-ID limit on read ID 3; other IDs still flow; retire unblocks next cycle.
    bus.rd_req_valid = 1; bus.rd_req_id = 4'd3;
    repeat (4) step();
    #1 check("id3_full_ready", bus.rd_req_ready, 0);
    step();
    bus.rd_req_id = 4'd4;
    #1 check("id4_ready", bus.rd_req_ready, 1);
    step();
    bus.rd_req_id = 4'd3;
    bus.rsp_valid = 1; bus.rsp_last = 1; bus.rsp_is_write = 0; bus.rsp_id = 4'd3;
    #1 check("id3_same_cycle_retire_ready", bus.rd_req_ready, 0);
    step();
    bus.rsp_valid = 0;
    #1 check("id3_after_retire_ready", bus.rd_req_ready, 1);
    step();
    drain();

    // Total limit: 16 grants across IDs, then one retire frees one slot.
    bus.rd_req_valid = 1; bus.wr_req_valid = 1;
    for (int k = 0; k < 16; k++) begin
      bus.rd_req_id = 4'(k / 2); bus.wr_req_id = 4'(k / 2);
      step();
    end
    bus.rd_req_id = 4'd0; bus.wr_req_id = 4'd0;
    #1 check("full_total", outstanding_total, 16);
    check("full_rd_ready", bus.rd_req_ready, 0);
    check("full_wr_ready", bus.wr_req_ready, 0);
    step();
    bus.rsp_valid = 1; bus.rsp_last = 1; bus.rsp_is_write = 0; bus.rsp_id = 4'd0;
    step();
    bus.rsp_valid = 0;
    #1 check("retired_total", outstanding_total, 15);
    check("one_ready", 32'(bus.rd_req_ready) + 32'(bus.wr_req_ready), 1);
    step();
    check("refilled_total", outstanding_total, 16);
    drain();

    // Illegal read ID dropped; err_clear; orphan response.
    bus.rd_req_valid = 1; bus.rd_req_id = 4'd9;
    #1 check("illegal_ready", bus.rd_req_ready, 1);
    step();
    bus.rd_req_valid = 0;
    check("illegal_not_issued", bus.out_valid, 0);
    check("illegal_flag", err_illegal_id, 1);
    check("illegal_total", outstanding_total, 0);
    err_clear = 1;
    step();
    err_clear = 0;
    check("illegal_cleared", err_illegal_id, 0);
    bus.rsp_valid = 1; bus.rsp_last = 1; bus.rsp_is_write = 1; bus.rsp_id = 4'd1;
    step();
    bus.rsp_valid = 0;
    check("orphan_flag", err_orphan_rsp, 1);
    // Clear while a new orphan arrives: the flag must stay set.
    err_clear = 1; bus.rsp_valid = 1;
    step();
    check("orphan_wins_clear", err_orphan_rsp, 1);
    bus.rsp_valid = 0;
    step();
    err_clear = 0;
    check("orphan_cleared", err_orphan_rsp, 0);

    // Downstream stall holds the slot; then same-cycle grant+retire nets out.
    idle();
    bus.out_ready = 0;
    bus.rd_req_valid = 1; bus.rd_req_id = 4'd1;
    step();
    bus.rd_req_valid = 0;
    bus.wr_req_valid = 1; bus.wr_req_id = 4'd6;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_wr_ready", bus.wr_req_ready, 0);
      step();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_id", bus.out_id, 1);
      check("stall_out_is_write", bus.out_is_write, 0);
    end
    bus.out_ready = 1;
    step();
    check("post_stall_id", bus.out_id, 6);
    bus.wr_req_id = 4'd0;
    step();
    check("pre_net_total", outstanding_total, 3);
    bus.rsp_valid = 1; bus.rsp_last = 1; bus.rsp_is_write = 1; bus.rsp_id = 4'd0;
    step();
    check("net_total", outstanding_total, 3);
    drain();

    // Reset in the middle of traffic.
    bus.rd_req_valid = 1; bus.wr_req_valid = 1;
    for (int k = 0; k < 7; k++) begin
      bus.rd_req_id = 4'(k / 2); bus.wr_req_id = 4'(k / 2);
      step();
    end
    check("pre_reset_total", outstanding_total, 7);
    check("pre_reset_out_valid", bus.out_valid, 1);
    reset_n = 0;
    #1 check("mid_reset_out_valid", bus.out_valid, 0);
    check("mid_reset_total", outstanding_total, 0);
    check("mid_reset_busy", busy, 0);
    step();
    reset_n = 1;
    idle();
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.rd_req_valid = ($urandom_range(0, 9) < 6);
      bus.rd_req_id    = 4'($urandom_range(0, 9));
      bus.wr_req_valid = ($urandom_range(0, 9) < 6);
      bus.wr_req_id    = 4'($urandom_range(0, 9));
      bus.out_ready    = ($urandom_range(0, 9) < 7);
      bus.rsp_valid    = ($urandom_range(0, 9) < 4);
      bus.rsp_last     = ($urandom_range(0, 9) < 8);
      bus.rsp_is_write = 1'($urandom_range(0, 1));
      bus.rsp_id       = 4'($urandom_range(0, 8));
      err_clear        = ($urandom_range(0, 19) == 0);
      reset_n          = !($urandom_range(0, 599) == 0);
      step();
      reset_n = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_id_tracker.md
AXI4_ID_TRACKER -- requirements
Module: axi4_id_tracker

Interface
REQ-001 SHALL have parameter NUM_IDS, default 8, meaning legal IDs are 0..NUM_IDS-1 per direction.
REQ-002 SHALL have parameter MAX_PER_ID, default 4, meaning max outstanding transactions per (direction, ID).
REQ-003 SHALL have parameter MAX_TOTAL, default 16, meaning max outstanding transactions summed over both directions.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have ports rd_req_valid/rd_req_ready, input/output, 1 each, read requester handshake.
REQ-007 SHALL have port rd_req_id, input, 4, read request ID.
REQ-008 SHALL have ports wr_req_valid/wr_req_ready, input/output, 1 each, write requester handshake.
REQ-009 SHALL have port wr_req_id, input, 4, write request ID.
REQ-010 SHALL have ports out_valid/out_ready, output/input, 1 each, shared downstream issue handshake.
REQ-011 SHALL have ports out_id (output, 4) and out_is_write (output, 1), the issued transaction's ID and direction.
REQ-012 SHALL have ports rsp_valid, rsp_last, rsp_is_write (input, 1 each) and rsp_id (input, 4), the response retire strobe; always accepted.
REQ-013 SHALL have port err_clear, input, 1, synchronous clear of sticky error flags.
REQ-014 SHALL have ports err_illegal_id and err_orphan_rsp, output, 1 each, sticky error flags.
REQ-015 SHALL have ports outstanding_total (output, 5) and busy (output, 1).

Function
REQ-016 SHALL keep one counter per (direction, ID), range 0..MAX_PER_ID, plus a total counter, range 0..MAX_TOTAL.
REQ-017 SHALL deem a request eligible iff valid, ID < NUM_IDS, its counter < MAX_PER_ID, total < MAX_TOTAL, and the output slot is empty or draining this cycle (out_valid && out_ready).
REQ-018 SHALL arbitrate eligible rd/wr requests round-robin: one grant per cycle; priority pointer flips to the other direction after each granted transfer; reset priority is read.
REQ-019 SHALL drive req_ready combinationally from registered state only, never from req_valid of the same requester.
REQ-020 SHALL load a granted request into a one-entry output register; out_valid rises the cycle after the grant (latency 1).
REQ-021 SHALL hold out_valid, out_id, out_is_write stable while out_valid && !out_ready.
REQ-022 SHALL increment the (direction, ID) and total counters on grant, not on downstream acceptance.
REQ-023 SHALL accept and drop a request with ID >= NUM_IDS (ready=1 when output slot not needed), not forward it, set err_illegal_id, change no counter; the dropped transfer counts as that direction's grant for priority purposes.
REQ-024 SHALL on rsp_valid && rsp_last with legal ID and counter > 0 decrement that counter and the total next cycle.
REQ-025 SHALL on rsp_valid && rsp_last with illegal ID or counter == 0 set err_orphan_rsp and change no counter.
REQ-026 SHALL ignore rsp_valid with rsp_last == 0 (no count change, no error).
REQ-027 SHALL net a same-cycle grant and retire on the same (direction, ID) to zero change; total likewise nets.
REQ-028 SHALL let a same-cycle retire not unblock a same-cycle request (eligibility uses pre-edge counts).
REQ-029 SHALL clear error flags on err_clear; a same-cycle new error SHALL win (flag stays set).
REQ-030 SHALL drive busy = (outstanding_total != 0) || out_valid.

Reset
REQ-031 SHALL on reset_n low asynchronously clear all counters, output slot, error flags and priority pointer to read; outputs: out_valid=0, out_id=0, out_is_write=0, rd/wr_req_ready=0 during reset, err_*=0, outstanding_total=0, busy=0.
REQ-032 SHALL on reset mid-transaction discard the held output entry and all outstanding counts without error reporting.

Verification
REQ-033 Both rd (ID 2) and wr (ID 5) valid every cycle, out_ready=1 -> grants alternate R,W,R,W starting with read; out_valid 1 cycle after each grant.
REQ-034 Four rd grants on ID 3, no responses -> rd_req_ready=0 for ID 3 while ID 4 still granted; one rsp_last for rd ID 3 -> ID 3 eligible the following cycle.
REQ-035 16 grants across IDs, no responses -> both readies 0, outstanding_total=16; one retire -> total 15 and one grant allowed.
REQ-036 rd_req_id=9 -> accepted, not issued, err_illegal_id=1; err_clear -> 0; rsp_last for wr ID 1 with count 0 -> err_orphan_rsp=1.
REQ-037 out_ready=0 for 3 cycles with out_valid=1 -> out_id/out_is_write stable, no further grants; grant + retire same cycle on wr ID 0 (count 1) -> count stays 1.
REQ-038 reset_n pulsed low with out_valid=1 and total=7 -> immediately out_valid=0, total=0, busy=0, errors 0.
